// File: rtl/checksum_accumulator_pkg.sv
// Shared definitions for the checksum accumulator.
//   state_e      : frame FSM states (accept data, accept checksum, publish result)
//   CHK_MODE_*   : checksum comparison modes
package checksum_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_CHK = 2'd1,
        ST_FIN = 2'd2
    } state_e;

    // ok = (sum == chk)
    localparam int unsigned CHK_MODE_EQ  = 0;
    // ok = ((sum + chk) mod 2^WIDTH == 0), i.e. chk is the two's complement of sum
    localparam int unsigned CHK_MODE_NEG = 1;

endpackage

// File: rtl/checksum_accumulator_add_mod.sv
// WIDTH-bit combinational modular adder; carry out is discarded.
//   a, b : addends
//   sum  : (a + b) mod 2^WIDTH
module checksum_accumulator_add_mod #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/checksum_accumulator.sv
// Accumulates N_WORDS data words modulo 2^WIDTH, then takes one checksum word and
// publishes the sum plus a match flag for one cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous frame restart (wins over in_valid)
//   in_valid  : in_data valid this cycle
//   in_ready  : word accepted this cycle if in_valid
//   in_data   : data word or checksum word
//   busy      : part of a frame has been accepted
//   sum_out   : modular sum of the last completed frame (held)
//   ok        : checksum result of the last completed frame (held)
//   done      : one-cycle pulse, sum_out/ok just updated
module checksum_accumulator
    import checksum_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N_WORDS  = 4,
    parameter int unsigned CHK_MODE = CHK_MODE_EQ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic [WIDTH-1:0] sum_out,
    output logic             ok,
    output logic             done
);

    localparam int unsigned CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ok_q, ok_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] acc_plus_in;
    logic             accept;
    logic             chk_match;

    // In ACC this is the running sum; in CHK it is sum + chk, which is what the
    // two's-complement check needs.
    checksum_accumulator_add_mod #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (acc_plus_in)
    );

    assign in_ready = (state_q != ST_FIN);
    assign accept   = in_valid && in_ready && !clear;

    always_comb begin
        if (CHK_MODE == CHK_MODE_NEG) begin
            chk_match = (acc_plus_in == '0);
        end else begin
            chk_match = (acc_q == in_data);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ok_d    = ok_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_d = acc_plus_in;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_CHK;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        sum_d   = acc_q;
                        ok_d    = chk_match;
                        done_d  = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_FIN;
                    end
                end
                ST_FIN: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
                default: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == ST_CHK) || ((state_q == ST_ACC) && (cnt_q != '0));
    assign sum_out = sum_q;
    assign ok      = ok_q;
    assign done    = done_q;

endmodule

// File: tb/tb_checksum_accumulator.sv
module tb_checksum_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // default instance: WIDTH 8, N_WORDS 4, CHK_MODE 0
    logic       clear0 = 1'b0, valid0 = 1'b0, ready0, busy0, ok0, done0;
    logic [7:0] data0 = '0, sum0;

    // CHK_MODE 1, WIDTH 16, N_WORDS 2
    logic        clear1 = 1'b0, valid1 = 1'b0, ready1, busy1, ok1, done1;
    logic [15:0] data1 = '0, sum1;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] fw[4];

    always #5 clk = ~clk;

    checksum_accumulator dut0 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear0),
        .in_valid (valid0),
        .in_ready (ready0),
        .in_data  (data0),
        .busy     (busy0),
        .sum_out  (sum0),
        .ok       (ok0),
        .done     (done0)
    );

    checksum_accumulator #(
        .WIDTH    (16),
        .N_WORDS  (2),
        .CHK_MODE (1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear1),
        .in_valid (valid1),
        .in_ready (ready1),
        .in_data  (data1),
        .busy     (busy1),
        .sum_out  (sum1),
        .ok       (ok1),
        .done     (done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int which);
        return (which == 0) ? ready0 : ready1;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy0 : busy1;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 0) ? done0 : done1;
    endfunction

    function automatic logic get_ok(input int which);
        return (which == 0) ? ok0 : ok1;
    endfunction

    function automatic logic [15:0] get_sum(input int which);
        return (which == 0) ? {8'h00, sum0} : sum1;
    endfunction

    // Called at posedge+1; presents one word for exactly one edge.
    task automatic send_w(input int which, input logic [15:0] d, input string tag);
        if (which == 0) begin
            valid0 = 1'b1;
            data0  = d[7:0];
        end else begin
            valid1 = 1'b1;
            data1  = d;
        end
        check_eq({tag, " in_ready"}, 32'(get_ready(which)), 32'd1);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic idle_gap(input int which, input int maxgap, input logic exp_busy,
                            input string tag);
        int gap;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
            check_eq({tag, " busy gap"}, 32'(get_busy(which)), 32'(exp_busy));
        end
    endtask

    // Sends fw[0..nw-1] then chk, checks the publish cycle and the cycle after.
    task automatic run_frame(input int which, input int nw, input logic [15:0] chk,
                             input int maxgap, input logic [15:0] exp_sum,
                             input logic exp_ok, input string tag);
        for (int i = 0; i < nw; i++) begin
            idle_gap(which, maxgap, i > 0, tag);
            send_w(which, fw[i], tag);
            check_eq({tag, " busy"}, 32'(get_busy(which)), 32'd1);
        end
        idle_gap(which, maxgap, 1'b1, tag);
        send_w(which, chk, tag);
        check_eq({tag, " done"}, 32'(get_done(which)), 32'd1);
        check_eq({tag, " fin ready"}, 32'(get_ready(which)), 32'd0);
        check_eq({tag, " fin busy"}, 32'(get_busy(which)), 32'd0);
        check_eq({tag, " sum"}, 32'(get_sum(which)), 32'(exp_sum));
        check_eq({tag, " ok"}, 32'(get_ok(which)), 32'(exp_ok));
        @(posedge clk);
        #1;
        check_eq({tag, " done drop"}, 32'(get_done(which)), 32'd0);
        check_eq({tag, " ready back"}, 32'(get_ready(which)), 32'd1);
        check_eq({tag, " sum held"}, 32'(get_sum(which)), 32'(exp_sum));
        check_eq({tag, " ok held"}, 32'(get_ok(which)), 32'(exp_ok));
    endtask

    task automatic load_frame1();
        fw[0] = 16'h35; fw[1] = 16'h00; fw[2] = 16'h18; fw[3] = 16'h00;
    endtask

    initial begin
        // reset state
        #2;
        check_eq("rst sum", 32'(sum0), 32'h0);
        check_eq("rst ok", 32'(ok0), 32'h0);
        check_eq("rst done", 32'(done0), 32'h0);
        check_eq("rst busy", 32'(busy0), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rel ready", 32'(ready0), 32'd1);

        // 1: back-to-back default frame
        load_frame1();
        run_frame(0, 4, 16'h4D, 0, 16'h4D, 1'b1, "t1");

        // 2: overflow, good then bad checksum
        fw[0] = 16'hFF; fw[1] = 16'hFF; fw[2] = 16'h01; fw[3] = 16'h02;
        run_frame(0, 4, 16'h01, 0, 16'h01, 1'b1, "t2a");
        run_frame(0, 4, 16'h02, 0, 16'h01, 1'b0, "t2b");

        // 3: random gaps
        load_frame1();
        for (int r = 0; r < 3; r++) begin
            run_frame(0, 4, 16'h4D, 3, 16'h4D, 1'b1, "t3");
        end

        // prior frame leaves sum 0x01 / ok 0 so retention is visible
        fw[0] = 16'hFF; fw[1] = 16'hFF; fw[2] = 16'h01; fw[3] = 16'h02;
        run_frame(0, 4, 16'h02, 0, 16'h01, 1'b0, "t4pre");

        // 4: clear after 2 words, with a word offered in the clear cycle
        send_w(0, 16'h11, "t4");
        send_w(0, 16'h22, "t4");
        clear0 = 1'b1;
        valid0 = 1'b1;
        data0  = 8'h55;
        @(posedge clk);
        #1;
        clear0 = 1'b0;
        valid0 = 1'b0;
        check_eq("t4 clr busy", 32'(busy0), 32'd0);
        check_eq("t4 clr sum", 32'(sum0), 32'h01);
        check_eq("t4 clr ok", 32'(ok0), 32'd0);
        check_eq("t4 clr done", 32'(done0), 32'd0);
        load_frame1();
        run_frame(0, 4, 16'h4D, 0, 16'h4D, 1'b1, "t4");

        // 5: asynchronous reset mid-cycle after 3 words
        send_w(0, 16'h35, "t5");
        send_w(0, 16'h00, "t5");
        send_w(0, 16'h18, "t5");
        check_eq("t5 pre busy", 32'(busy0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5 sum", 32'(sum0), 32'h0);
        check_eq("t5 ok", 32'(ok0), 32'd0);
        check_eq("t5 busy", 32'(busy0), 32'd0);
        check_eq("t5 done", 32'(done0), 32'd0);
        #3;
        rst = 1'b0;
        #1;
        check_eq("t5 ready", 32'(ready0), 32'd1);
        @(posedge clk);
        #1;
        load_frame1();
        run_frame(0, 4, 16'h4D, 0, 16'h4D, 1'b1, "t5");

        // 6: two's-complement mode, 16-bit, 2 words
        fw[0] = 16'h1234; fw[1] = 16'h0F00;
        run_frame(1, 2, 16'hDECC, 0, 16'h2134, 1'b1, "t6a");
        run_frame(1, 2, 16'h2134, 0, 16'h2134, 1'b0, "t6b");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
